// File: rtl/if_fetch_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_buf
// Instruction fetch stage sitting directly upstream of decode. Owns the PC,
// issues word-aligned fetches on a req/gnt/rvalid instruction bus, buffers the
// returned words in a DEPTH-entry FIFO, and presents the FIFO head to id.
// A jump from ex redirects the PC, flushes the FIFO and drops any responses
// still in flight for the old path (DRAIN state until they have all returned).
//
// Optional feature (macro IFB_BYPASS_EN):
//   defined   - a response arriving while the FIFO is empty and nothing is
//               being discarded is shown to id in the same cycle; if id does
//               not stall it is consumed there and never enters the FIFO.
//   undefined - id only ever sees the registered FIFO head.
//
// Parameters:
//   RESET_ADDR  first fetch PC after reset
//   DEPTH       FIFO entries and max (in-flight + buffered) credit, 2^n >= 2
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   jump_flag_i     redirect pulse from ex (wins over hold_i and pop)
//   jump_addr_i     redirect target, bits [1:0] ignored
//   hold_i          id stall, head not consumed this cycle
//   ibus_req_o      fetch request valid
//   ibus_addr_o     fetch address (current PC)
//   ibus_gnt_i      request accepted when ibus_req_o && ibus_gnt_i
//   ibus_rvalid_i   in-order response valid, at least one cycle after grant
//   ibus_rdata_i    response instruction word
//   inst_o          instruction to id, NOP when not valid
//   inst_addr_o     PC of inst_o, zero when not valid
//   inst_valid_o    instruction valid to id
// -----------------------------------------------------------------------------
module if_fetch_buf #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  // Architectural state
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;      // granted requests whose response is pending
  logic [CW-1:0] disc_q, disc_d;    // pending responses belonging to a dead path
  logic [CW-1:0] cnt_q, cnt_d;      // instruction FIFO occupancy
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   afifo_q [DEPTH];   // PCs of live in-flight requests, in grant order
  logic [31:0]   afifo_d [DEPTH];
  logic [AW-1:0] ard_q, ard_d, awr_q, awr_d;

  // Per-cycle control
  logic          rsp;
  logic          rsp_keep;
  logic          head_valid;
  logic          credit_ok;
  logic          req;
  logic          grant;
  logic          byp_hit;
  logic          byp_take;
  logic          push;
  logic          pop;
  logic [CW-1:0] disc_jump;

  // Handshake decode and credit
  always_comb begin
    rsp        = ibus_rvalid_i && (out_q != '0);
    rsp_keep   = rsp && (disc_q == '0);
    head_valid = (cnt_q != '0);
    credit_ok  = (SW'(out_q) + SW'(cnt_q)) < SW'(DEPTH);
    // rst gating keeps the bus quiet while reset is held
    req        = !rst && (state_q == ST_FETCH) && credit_ok && !jump_flag_i;
    grant      = req && ibus_gnt_i;
`ifdef IFB_BYPASS_EN
    byp_hit    = !rst && !head_valid && rsp_keep && !jump_flag_i;
`else
    byp_hit    = 1'b0;
`endif
    byp_take   = byp_hit && !hold_i;
    push       = rsp_keep && !jump_flag_i && !byp_take;
    pop        = head_valid && !hold_i && !jump_flag_i;
    // A response returning in the jump cycle is already accounted for
    disc_jump  = out_q - CW'(rsp);
  end

  assign ibus_req_o  = req;
  assign ibus_addr_o = pc_q;

  // Instruction presented to id
  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_addr_o  = 32'h0000_0000;
    if (byp_hit) begin
      inst_valid_o = 1'b1;
      inst_o       = ibus_rdata_i;
      inst_addr_o  = afifo_q[ard_q];
    end else if (head_valid) begin
      inst_valid_o = 1'b1;
      inst_o       = fifo_q[rd_q].data;
      inst_addr_o  = fifo_q[rd_q].addr;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + CW'(grant) - CW'(rsp);
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ard_d   = ard_q;
    awr_d   = awr_q;
    fifo_d  = fifo_q;
    afifo_d = afifo_q;

    if (jump_flag_i) begin
      // Redirect: nothing was granted this cycle, so both FIFOs simply empty
      pc_d    = {jump_addr_i[31:2], 2'b00};
      disc_d  = disc_jump;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      ard_d   = '0;
      awr_d   = '0;
      state_d = (disc_jump != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (grant) begin
        pc_d           = pc_q + 32'd4;
        afifo_d[awr_q] = pc_q;
        awr_d          = awr_q + AW'(1);
      end

      if (rsp_keep) begin
        ard_d = ard_q + AW'(1);
      end

      if (rsp && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end

      if (push) begin
        fifo_d[wr_q].addr = afifo_q[ard_q];
        fifo_d[wr_q].data = ibus_rdata_i;
        wr_d              = wr_q + AW'(1);
      end

      if (pop) begin
        rd_d = rd_q + AW'(1);
      end

      cnt_d = cnt_q + CW'(push) - CW'(pop);

      if ((state_q == ST_DRAIN) && (disc_d == '0)) begin
        state_d = ST_FETCH;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_ADDR;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ard_q   <= '0;
      awr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i]  <= '0;
        afifo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ard_q   <= ard_d;
      awr_q   <= awr_d;
      fifo_q  <= fifo_d;
      afifo_q <= afifo_d;
    end
  end

  // Structural invariants of the credit scheme
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt_q == CW'(DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (SW'(out_q) + SW'(cnt_q)) <= SW'(DEPTH));

  a_discard_bound: assert property (@(posedge clk) disable iff (rst)
    disc_q <= out_q);

endmodule

// File: tb/tb_if_fetch_buf.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_buf
// Drives if_fetch_buf with a queue-based instruction bus (random grant and
// response latency) and checks it against a count-level model of the fetch
// stage: which PC must be fetched next, which PC id must see next, how many
// live and stale requests exist. Directed scenario tasks follow the random run.
// -----------------------------------------------------------------------------
module tb_if_fetch_buf;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  if_fetch_buf #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } bus_t;

  // Bus and reference model state
  bus_t        bus_q[$];
  logic [31:0] cons_q[$];
  int          cyc;
  int          p_gnt;
  int          lat_min;
  int          lat_max;
  int          live;          // fetches since last redirect not yet taken by id
  int          stale;         // responses still owed for a dead path
  int          arrived;       // live responses returned but not yet taken
  int          consumed_cnt;
  logic [31:0] m_pc;
  logic [31:0] exp_addr;
  logic [31:0] rd_xor;

  int n_chk;
  int n_fail;

  logic        obs_req;
  logic [31:0] obs_iaddr;
  logic        obs_valid;
  logic [31:0] obs_inst;
  logic [31:0] obs_inst_addr;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return (a | 32'h0000_0013) ^ rd_xor;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    jump_flag_i   = 1'b0;
    jump_addr_i   = '0;
    hold_i        = 1'b0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    bus_q.delete();
    cons_q.delete();
    live         = 0;
    stale        = 0;
    arrived      = 0;
    consumed_cnt = 0;
    m_pc         = RESET_ADDR;
    exp_addr     = RESET_ADDR;
    rd_xor       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One bus/id cycle: drive at negedge, sample 1ns later, compare, advance model
  task automatic step(input bit jmp, input logic [31:0] tgt, input int hold_mode);
    bit          rv;
    bit          exp_req;
    bit          exp_valid;
    bit          consume;
    bit          from_fifo;
    logic [31:0] rdat;
    int          rdy;
    @(negedge clk);
    jump_flag_i = jmp;
    jump_addr_i = tgt;
    if (hold_mode == 2) hold_i = ($urandom_range(0, 99) < 30);
    else                hold_i = (hold_mode != 0);
    ibus_gnt_i = ($urandom_range(0, 99) < p_gnt);
    rv = (bus_q.size() > 0) && (bus_q[0].ready <= cyc);
    rdat = $urandom();
    if (rv) rdat = data_fn(bus_q[0].addr);
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rdat;
    #1;
    obs_req       = ibus_req_o;
    obs_iaddr     = ibus_addr_o;
    obs_valid     = inst_valid_o;
    obs_inst      = inst_o;
    obs_inst_addr = inst_addr_o;

    exp_req = !jmp && (stale == 0) && (live < DEPTH);
    n_chk++;
    if (ibus_req_o !== exp_req) begin
      n_fail++;
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, ibus_req_o, exp_req);
    end
    n_chk++;
    if (ibus_addr_o !== m_pc) begin
      n_fail++;
      $display("FAIL ibus_addr cyc=%0d got=%h exp=%h", cyc, ibus_addr_o, m_pc);
    end

    exp_valid = (arrived > 0) || (BYP && rv && (stale == 0) && !jmp);
    n_chk++;
    if (inst_valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_o, exp_valid);
    end
    if (exp_valid) begin
      n_chk++;
      if (inst_addr_o !== exp_addr || inst_o !== data_fn(exp_addr)) begin
        n_fail++;
        $display("FAIL inst_head cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_addr_o, inst_o,
                 exp_addr, data_fn(exp_addr));
      end
    end else begin
      n_chk++;
      if (inst_o !== NOP_INST || inst_addr_o !== 32'h0) begin
        n_fail++;
        $display("FAIL inst_idle cyc=%0d got=%h/%h exp=%h/00000000", cyc, inst_o, inst_addr_o,
                 NOP_INST);
      end
    end

    consume   = exp_valid && !hold_i && !jmp;
    from_fifo = (arrived > 0);
    if (consume) begin
      cons_q.push_back(inst_addr_o);
      exp_addr = exp_addr + 32'd4;
      live--;
      consumed_cnt++;
      if (from_fifo) arrived--;
    end
    if (rv) void'(bus_q.pop_front());

    if (jmp) begin
      stale    = bus_q.size();
      live     = 0;
      arrived  = 0;
      exp_addr = {tgt[31:2], 2'b00};
      m_pc     = {tgt[31:2], 2'b00};
    end else begin
      if (rv) begin
        if (stale > 0) stale--;
        else if (!(consume && !from_fifo)) arrived++;
      end
      if (ibus_req_o && ibus_gnt_i) begin
        live++;
        rdy = cyc + int'($urandom_range(lat_min, lat_max));
        if (bus_q.size() > 0 && rdy < bus_q[$].ready) rdy = bus_q[$].ready;
        bus_q.push_back('{addr: ibus_addr_o, ready: rdy});
        m_pc = m_pc + 32'd4;
      end
    end

    n_chk++;
    if (live + stale > DEPTH) begin
      n_fail++;
      $display("FAIL occupancy cyc=%0d got=%0d exp<=%0d", cyc, live + stale, DEPTH);
    end
    cyc++;
  endtask

  task automatic test_reset();
    jump_flag_i = 0; jump_addr_i = 0; hold_i = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (ibus_req_o !== 1'b0 || ibus_addr_o !== RESET_ADDR) begin
      n_fail++;
      $display("FAIL reset_bus got=%b/%h exp=0/%h", ibus_req_o, ibus_addr_o, RESET_ADDR);
    end
    n_chk++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP_INST || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_inst got=%b/%h/%h exp=0/%h/0", inst_valid_o, inst_o, inst_addr_o,
               NOP_INST);
    end
    do_reset();
    #1;
    n_chk++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== RESET_ADDR) begin
      n_fail++;
      $display("FAIL reset_first_req got=%b/%h exp=1/%h", ibus_req_o, ibus_addr_o, RESET_ADDR);
    end
  endtask

  task automatic test_stream();
    do_reset();
    p_gnt = 100; lat_min = 1; lat_max = 1;
    repeat (40) step(1'b0, 32'h0, 0);
    n_chk++;
    if (consumed_cnt < 10) begin
      n_fail++;
      $display("FAIL stream_count got=%0d exp>=10", consumed_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (cons_q.size() <= k || cons_q[k] !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_order k=%0d got=%h exp=%h", k,
                 (cons_q.size() > k) ? cons_q[k] : 32'hx, 32'(4 * k));
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    p_gnt = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && consumed_cnt < 1; i++) step(1'b0, 32'h0, 0);
    repeat (5) step(1'b0, 32'h0, 1);
    n_chk++;
    if (obs_valid !== 1'b1 || obs_inst_addr !== 32'h4 || obs_inst !== data_fn(32'h4)) begin
      n_fail++;
      $display("FAIL hold_head got=%b/%h/%h exp=1/00000004/%h", obs_valid, obs_inst_addr, obs_inst,
               data_fn(32'h4));
    end
    n_chk++;
    if (obs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_req got=%b exp=0", obs_req);
    end
    cons_q.delete();
    repeat (8) step(1'b0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (cons_q.size() <= k || cons_q[k] !== 32'(4 + 4 * k)) begin
        n_fail++;
        $display("FAIL hold_release k=%0d got=%h exp=%h", k,
                 (cons_q.size() > k) ? cons_q[k] : 32'hx, 32'(4 + 4 * k));
      end
    end
  endtask

  task automatic test_jump_drain();
    do_reset();
    p_gnt = 100; lat_min = 5; lat_max = 5;
    step(1'b1, 32'h10, 0);
    repeat (3) step(1'b0, 32'h0, 0);
    step(1'b1, 32'h103, 0);
    n_chk++;
    if (obs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_cycle_req got=%b exp=0", obs_req);
    end
    lat_min = 1; lat_max = 1;
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_req !== 1'b0 || obs_iaddr !== 32'h100 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_state got=%b/%h/%b exp=0/00000100/0", obs_req, obs_iaddr, obs_valid);
    end
    cons_q.delete();
    for (int i = 0; i < 40 && cons_q.size() == 0; i++) step(1'b0, 32'h0, 0);
    n_chk++;
    if (cons_q.size() == 0 || cons_q[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_first got=%h exp=00000100", (cons_q.size() > 0) ? cons_q[0] : 32'hx);
    end
  endtask

  task automatic test_jump_rvalid();
    do_reset();
    p_gnt = 100; lat_min = 2; lat_max = 2;
    step(1'b0, 32'h0, 0);
    p_gnt = 0;
    step(1'b0, 32'h0, 0);
    step(1'b1, 32'h40, 0);
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_req !== 1'b1 || obs_iaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL jump_rvalid_req got=%b/%h exp=1/00000040", obs_req, obs_iaddr);
    end
    p_gnt = 100; lat_min = 1; lat_max = 1;
    cons_q.delete();
    for (int i = 0; i < 40 && cons_q.size() == 0; i++) step(1'b0, 32'h0, 0);
    n_chk++;
    if (cons_q.size() == 0 || cons_q[0] !== 32'h40) begin
      n_fail++;
      $display("FAIL jump_rvalid_first got=%h exp=00000040", (cons_q.size() > 0) ? cons_q[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    p_gnt = 100; lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC, 0);
    cons_q.delete();
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_iaddr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_pre got=%h exp=fffffffc", obs_iaddr);
    end
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_iaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_post got=%h exp=00000000", obs_iaddr);
    end
    for (int i = 0; i < 40 && cons_q.size() < 2; i++) step(1'b0, 32'h0, 0);
    n_chk++;
    if (cons_q.size() < 2 || cons_q[0] !== 32'hFFFF_FFFC || cons_q[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_inst got=%h,%h exp=fffffffc,00000000",
               (cons_q.size() > 0) ? cons_q[0] : 32'hx, (cons_q.size() > 1) ? cons_q[1] : 32'hx);
    end
  endtask

  task automatic test_bypass_latency();
    do_reset();
    rd_xor = 32'h0050_0080;
    p_gnt = 100; lat_min = 1; lat_max = 1;
    step(1'b0, 32'h0, 0);
    p_gnt = 0;
    step(1'b0, 32'h0, 0);
    if (BYP) begin
      n_chk++;
      if (obs_valid !== 1'b1 || obs_inst !== 32'h0050_0093 || obs_inst_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL bypass_same_cycle got=%b/%h/%h exp=1/00500093/00000000", obs_valid, obs_inst,
                 obs_inst_addr);
      end
    end else begin
      n_chk++;
      if (obs_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fifo_latency_early got=%b exp=0", obs_valid);
      end
      step(1'b0, 32'h0, 0);
      n_chk++;
      if (obs_valid !== 1'b1 || obs_inst !== 32'h0050_0093 || obs_inst_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL fifo_latency got=%b/%h/%h exp=1/00500093/00000000", obs_valid, obs_inst,
                 obs_inst_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    p_gnt = 100; lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, 32'h0, 1);
    n_chk++;
    if (obs_valid !== 1'b1 || obs_inst_addr !== 32'h0 || obs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full_before_reset got=%b/%h/%b exp=1/00000000/0", obs_valid, obs_inst_addr,
               obs_req);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP_INST ||
        inst_addr_o !== 32'h0 || ibus_addr_o !== RESET_ADDR) begin
      n_fail++;
      $display("FAIL reset_mid got=%b/%b/%h/%h/%h exp=0/0/%h/00000000/%h", ibus_req_o,
               inst_valid_o, inst_o, inst_addr_o, ibus_addr_o, NOP_INST, RESET_ADDR);
    end
    do_reset();
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_req !== 1'b1 || obs_iaddr !== RESET_ADDR) begin
      n_fail++;
      $display("FAIL reset_mid_restart got=%b/%h exp=1/%h", obs_req, obs_iaddr, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    bit          jmp;
    logic [31:0] tgt;
    do_reset();
    p_gnt = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      jmp = ($urandom_range(0, 99) < 4);
      tgt = $urandom();
      step(jmp, tgt, 2);
    end
    p_gnt = 0;
    for (int i = 0; i < 100 && (live > 0 || stale > 0); i++) step(1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 0);
    n_chk++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1) begin
      n_fail++;
      $display("FAIL random_drain got=%b/%b exp=0/1", obs_valid, obs_req);
    end
    n_chk++;
    if (consumed_cnt < 100) begin
      n_fail++;
      $display("FAIL random_progress got=%0d exp>=100", consumed_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    n_chk = 0; n_fail = 0; cyc = 0;
    p_gnt = 100; lat_min = 1; lat_max = 1;
    live = 0; stale = 0; arrived = 0; consumed_cnt = 0;
    m_pc = RESET_ADDR; exp_addr = RESET_ADDR; rd_xor = '0;
    test_reset();
    test_stream();
    test_hold();
    test_jump_drain();
    test_jump_rvalid();
    test_wrap();
    test_bypass_latency();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
